mips_regfile: RTL and testbench

//   32 x 32-bit general-purpose register file for the MIPS CPU; responder for the decode stage's read requests.
//   Two combinational read ports serve the decode stage's reg1/reg2 (read-enable, address) requests.
//   One synchronous write port is driven from write-back.
//   A post-reset clear sequencer zeroes storage one entry per cycle so the array can map to RAM.

---
 rtl/mips_regfile_if.sv | 49 ++++
 rtl/mips_regfile.sv | 167 ++++++++++++++++
 tb/tb_mips_regfile.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mips_regfile_if.sv
// rtl/mips_regfile_if.sv - decode/write-back bus to the register file; parity signals under REGFILE_PARITY_EN
interface mips_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // write-back write port
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // decode read ports
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  // status
  logic              init_busy;

`ifdef REGFILE_PARITY_EN
  logic              perr1;
  logic              perr2;
  logic              perr_sticky;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, init_busy, perr1, perr2, perr_sticky
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, init_busy, perr1, perr2, perr_sticky
  );
`else
  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, init_busy
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, init_busy
  );
`endif

endinterface

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 MIPS register file, 2 comb read ports, 1 write port, post-reset clear; optional parity via REGFILE_PARITY_EN
module mips_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mips_regfile_if.slave rf
);

`ifdef REGFILE_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [ADDR_W-1:0] w_clr_ptr_nxt;
  logic              r_init_busy;
  logic              w_init_busy_nxt;

  // Storage has no reset so it can map onto a RAM; entry 0 is never written.
  logic [MEM_W-1:0]  r_mem [0:NUM_REGS-1];

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [MEM_W-1:0]  w_mem_data;

  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic              w_rd_blocked;

`ifdef REGFILE_PARITY_EN
  logic              w_perr1;
  logic              w_perr2;
  logic              r_perr_sticky;
`endif

  // Sequencer state: reset restarts the clear walk at entry 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_CLEAR;
      r_clr_ptr   <= FIRST_PTR;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_ptr   <= w_clr_ptr_nxt;
      r_init_busy <= w_init_busy_nxt;
    end
  end

  // Next state and array write selection: clear walk owns the write port until READY.
  always_comb begin
    w_state_nxt     = r_state;
    w_clr_ptr_nxt   = r_clr_ptr;
    w_init_busy_nxt = r_init_busy;
    w_mem_we        = 1'b0;
    w_mem_addr      = '0;
    w_mem_data      = '0;
    if (!i_rst) begin
      case (r_state)
        S_CLEAR: begin
          w_mem_we   = 1'b1;
          w_mem_addr = r_clr_ptr;
          w_mem_data = '0;
          if (r_clr_ptr == LAST_PTR) begin
            w_state_nxt     = S_READY;
            w_init_busy_nxt = 1'b0;
          end else begin
            w_clr_ptr_nxt = r_clr_ptr + FIRST_PTR;
          end
        end
        S_READY: begin
          w_init_busy_nxt = 1'b0;
          if (rf.we && (rf.waddr != '0)) begin
            w_mem_we   = 1'b1;
            w_mem_addr = rf.waddr;
`ifdef REGFILE_PARITY_EN
            w_mem_data = {^rf.wdata, rf.wdata};
`else
            w_mem_data = rf.wdata;
`endif
          end
        end
        default: begin
          w_state_nxt = S_CLEAR;
        end
      endcase
    end
  end

  // Single array write port shared by the clear walk and write-back.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign w_rd_blocked = i_rst || r_init_busy;

  // Read port 1: zero while blocked/disabled/r0, bypass a same-cycle write, else storage.
  always_comb begin
    w_rdata1 = '0;
`ifdef REGFILE_PARITY_EN
    w_perr1  = 1'b0;
`endif
    if (!w_rd_blocked && rf.re1 && (rf.raddr1 != '0)) begin
      if (rf.we && (rf.waddr == rf.raddr1)) begin
        w_rdata1 = rf.wdata;
      end else begin
        w_rdata1 = r_mem[rf.raddr1][DATA_W-1:0];
`ifdef REGFILE_PARITY_EN
        w_perr1  = (^r_mem[rf.raddr1][DATA_W-1:0]) != r_mem[rf.raddr1][DATA_W];
`endif
      end
    end
  end

  // Read port 2: same priority as port 1; both may bypass together.
  always_comb begin
    w_rdata2 = '0;
`ifdef REGFILE_PARITY_EN
    w_perr2  = 1'b0;
`endif
    if (!w_rd_blocked && rf.re2 && (rf.raddr2 != '0)) begin
      if (rf.we && (rf.waddr == rf.raddr2)) begin
        w_rdata2 = rf.wdata;
      end else begin
        w_rdata2 = r_mem[rf.raddr2][DATA_W-1:0];
`ifdef REGFILE_PARITY_EN
        w_perr2  = (^r_mem[rf.raddr2][DATA_W-1:0]) != r_mem[rf.raddr2][DATA_W];
`endif
      end
    end
  end

`ifdef REGFILE_PARITY_EN
  // Sticky parity flag: any port error since the last reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perr_sticky <= 1'b0;
    end else if (w_perr1 || w_perr2) begin
      r_perr_sticky <= 1'b1;
    end
  end

  assign rf.perr1       = w_perr1;
  assign rf.perr2       = w_perr2;
  assign rf.perr_sticky = r_perr_sticky;
`endif

  assign rf.rdata1    = w_rdata1;
  assign rf.rdata2    = w_rdata2;
  assign rf.init_busy = r_init_busy;

endmodule

// File: tb/tb_mips_regfile.sv
// tb/tb_mips_regfile.sv - self-checking bench for mips_regfile (vector table + scoreboard queue)
module tb_mips_regfile;

  logic clk;
  logic rst;

  mips_regfile_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  mips_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .rf    (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, queue the expectation, compare before the edge, advance.
  task automatic step(input string name, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2,
                      input logic [31:0] e1, input logic [31:0] e2, input logic eb);
    exp_t e;
    rf.we = we; rf.waddr = wa; rf.wdata = wd;
    rf.re1 = re1; rf.raddr1 = ra1; rf.re2 = re2; rf.raddr2 = ra2;
    sb.push_back('{d1: e1, d2: e2, busy: eb});
    #2;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", name);
    end else begin
      n_tests--;
      e = sb.pop_front();
      check({name, ".rdata1"}, rf.rdata1, e.d1);
      check({name, ".rdata2"}, rf.rdata2, e.d2);
      check({name, ".busy"}, 32'(rf.init_busy), 32'(e.busy));
    end
    @(posedge clk); #1;
  endtask

  // Counts cycles with init_busy high, bounded so a stuck sequencer still ends the run.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (rf.init_busy !== 1'b1) break;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 1; i <= 31; i++) begin
      step(name, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i), 32'h0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nb;

    //        we    wa     wdata          re1  ra1    re2  ra2    exp1           exp2
    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,        32'h0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd0,  32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 5'd7,  32'h12345678, 1'b1, 5'd5,  1'b1, 5'd7,  32'hDEADBEEF, 32'h12345678};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b1, 5'd7,  32'h0,        32'h12345678};
    tbl[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0,        32'h0};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5,  1'b0, 5'd7,  32'h0,        32'h0};
    tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[8]  = '{1'b1, 5'd9,  32'hCAFEF00D, 1'b1, 5'd9,  1'b1, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b1, 5'd9,  32'hCAFEF00D, 32'hCAFEF00D};
    tbl[10] = '{1'b1, 5'd5,  32'h01234567, 1'b1, 5'd5,  1'b1, 5'd7,  32'h01234567, 32'h12345678};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd31, 32'h01234567, 32'h0};
    tbl[12] = '{1'b1, 5'd31, 32'h80000001, 1'b1, 5'd31, 1'b1, 5'd30, 32'h80000001, 32'h0};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd0,  32'h80000001, 32'h0};
    tbl[14] = '{1'b1, 5'd4,  32'h0BADF00D, 1'b1, 5'd5,  1'b1, 5'd4,  32'h01234567, 32'h0BADF00D};

    rst = 1'b1;
    rf.we = 1'b0; rf.waddr = '0; rf.wdata = '0;
    rf.re1 = 1'b0; rf.raddr1 = '0; rf.re2 = 1'b0; rf.raddr2 = '0;

    // Two-cycle reset; reads and writes are suppressed while rst is high.
    @(posedge clk); #1;
    step("rst_read", 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 1'b1, 5'd5, 32'h0, 32'h0, 1'b1);
    rst = 1'b0;
    rf.we = 1'b0; rf.re1 = 1'b0; rf.re2 = 1'b0;
    count_busy(nb);
    check("busy_len_first", 32'(nb), 32'd31);
    read_all_zero("clr_read_first");

    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].re1, tbl[i].ra1,
           tbl[i].re2, tbl[i].ra2, tbl[i].e1, tbl[i].e2, 1'b0);
    end

    // Reset mid-clear restarts the walk; writes issued while busy are dropped.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step("busy_drop", 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3, 1'b1, 5'd5, 32'h0, 32'h0, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(nb);
    check("busy_len_restart", 32'(nb), 32'd31);
    rf.we = 1'b0;
    step("r3_dropped", 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0);
    read_all_zero("clr_read_restart");

`ifdef REGFILE_PARITY_EN
    step("par_wr", 1'b1, 5'd9, 32'h00000013, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    rf.we = 1'b0; rf.re1 = 1'b1; rf.raddr1 = 5'd9; rf.re2 = 1'b0;
    #2;
    check("perr1_clean", 32'(rf.perr1), 32'd0);
    check("rdata_clean", rf.rdata1, 32'h00000013);
    @(posedge clk); #1;
    dut.r_mem[9][32] = ~dut.r_mem[9][32];
    #1;
    check("perr1_bad", 32'(rf.perr1), 32'd1);
    check("rdata_bad_unmod", rf.rdata1, 32'h00000013);
    check("sticky_before", 32'(rf.perr_sticky), 32'd0);
    @(posedge clk); #1;
    check("sticky_set", 32'(rf.perr_sticky), 32'd1);
    rf.re1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("perr1_idle", 32'(rf.perr1), 32'd0);
    check("sticky_hold", 32'(rf.perr_sticky), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("sticky_rst", 32'(rf.perr_sticky), 32'd0);
    count_busy(nb);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
